// File: rtl/div_pkg.sv
// div_pkg: shared encodings for the RV32M divider and the hazard unit.
`default_nettype none

package div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   localparam int DIV_LATENCY = 34;

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// div_unit: RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit per cycle.
`default_nettype none

module div_unit
   import div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   div_state_e      state_q, state_d;
   div_op_e         op_q, op_d;
   logic [XLEN-1:0] dvd_q, dvd_d;     // dividend shifts out, quotient bits shift in
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            is_signed;
   logic            div_zero;
   logic            ovf;
   logic            is_rem_in;
   logic            is_rem_q;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic [XLEN+1:0] shifted;
   logic [XLEN+1:0] diff;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;

   assign is_signed = ~op[0];
   assign is_rem_in = op[1];
   assign is_rem_q  = (op_q == OP_REM) || (op_q == OP_REMU);
   assign div_zero  = (rs2 == '0);
   assign ovf       = is_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
   assign abs_a     = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
   assign abs_b     = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;

   // Extra top bit makes the trial subtraction's borrow visible in diff[XLEN+1].
   assign shifted   = {rem_q, dvd_q[XLEN-1]};
   assign diff      = shifted - {2'b00, dvs_q};
   assign q_fix     = qneg_q ? -dvd_q : dvd_q;
   assign r_fix     = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = div_op_e'(op);
               dvd_d  = abs_a;
               dvs_d  = abs_b;
               rem_d  = '0;
               cnt_d  = 5'd31;
               qneg_d = is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
               rneg_d = is_signed && rs1[XLEN-1];
               if (div_zero) begin
                  result_d = is_rem_in ? rs1 : '1;
                  state_d  = S_DONE;
               end else if (ovf) begin
                  result_d = is_rem_in ? '0 : rs1;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
            dvd_d = {dvd_q[XLEN-2:0], ~diff[XLEN+1]};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = is_rem_q ? r_fix : q_fix;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Flush drops everything in flight, including a same-cycle start or result update.
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_DIV;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= 5'd0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

endmodule

`default_nettype wire
